// File: rtl/booth_radix4_seq_multiplier_if.sv
// Handshake/bus bundle for booth_radix4_seq_multiplier.
// Ports (as seen by the multiplier through the slave modport):
//   start       in   request, sampled only while the multiplier is idle or done
//   signed_mode in   1 = two's complement operands, 0 = unsigned
//   X, Y        in   N-bit multiplicand / multiplier, latched with start
//   busy        out  high while a multiplication is in progress
//   done        out  one-cycle pulse, Product valid
//   Product     out  2N-bit result register
interface booth_radix4_seq_multiplier_if #(
    parameter int N = 32
) ();
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   X;
    logic [N-1:0]   Y;
    logic           busy;
    logic           done;
    logic [2*N-1:0] Product;

    modport master (
        output start, signed_mode, X, Y,
        input  busy, done, Product
    );

    modport slave (
        input  start, signed_mode, X, Y,
        output busy, done, Product
    );
endinterface

// File: rtl/booth_radix4_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, N x N -> 2N, two multiplier bits per clock.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of booth_radix4_seq_multiplier_if
//        (start, signed_mode, X, Y in; busy, done, Product out)
// Optional feature macro: BOOTH_ZERO_BYPASS_EN -- when defined, a start with a
// zero operand skips the iterations and reports Product = 0 one cycle later.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one Booth step per cycle, busy = 1
// DONE  | done = 1 for one cycle; start here launches the next operation
module booth_radix4_seq_multiplier #(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N/2+2)
) (
    input  logic                                clk,
    input  logic                                rst,
    booth_radix4_seq_multiplier_if.slave        bus
);
    localparam int W = N + 2;       // extended operand width
    localparam int M = N/2 + 1;     // radix-4 steps

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_x;
    logic [2*W:0]   r_p;            // {acc, multiplier, guard y[-1]}
    logic [CNT_W-1:0] r_cnt;
    logic [2*N-1:0] r_product;

    logic           w_load;
    logic           w_last;
    logic           w_bypass;
    logic           w_busy;
    logic           w_done;
    logic [W-1:0]   w_x_ext;
    logic [W-1:0]   w_y_ext;
    logic [W:0]     w_addend;
    logic [W:0]     w_sum;
    logic [2*W:0]   w_p_next;

    assign w_load  = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_last  = (r_cnt == CNT_W'(M-1));
    assign w_x_ext = bus.signed_mode ? {{2{bus.X[N-1]}}, bus.X} : {2'b00, bus.X};
    assign w_y_ext = bus.signed_mode ? {{2{bus.Y[N-1]}}, bus.Y} : {2'b00, bus.Y};

`ifdef BOOTH_ZERO_BYPASS_EN
    logic w_zero;
    assign w_zero   = (bus.X == '0) || (bus.Y == '0);
    assign w_bypass = w_zero;
`else
    assign w_bypass = 1'b0;
`endif

    // Booth digit from the low triplet; the sum is one bit wider than the
    // accumulator so +/-2X on a large unsigned operand cannot wrap before
    // the shift brings it back into range.
    always_comb begin
        w_addend = '0;
        case (r_p[2:0])
            3'b001, 3'b010: w_addend = {r_x[W-1], r_x};
            3'b011:         w_addend = {r_x, 1'b0};
            3'b100:         w_addend = -{r_x, 1'b0};
            3'b101, 3'b110: w_addend = -{r_x[W-1], r_x};
            default:        w_addend = '0;
        endcase
        w_sum    = {r_p[2*W], r_p[2*W:W+1]} + w_addend;
        w_p_next = {w_sum[W], w_sum, r_p[W:2]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_next = w_bypass ? DONE : CALC;
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (w_load) begin
                    w_state_next = w_bypass ? DONE : CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_x   <= w_x_ext;
            r_p   <= {{W{1'b0}}, w_y_ext, 1'b0};
            r_cnt <= '0;
            if (w_bypass) begin
                r_product <= '0;
            end
        end else if (r_state == CALC) begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + CNT_W'(1);
            // After M steps the register has shifted by 2M = W, so the
            // product sits just above the guard bit.
            if (w_last) begin
                r_product <= w_p_next[2*N:1];
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.Product = r_product;
endmodule
